// File: rtl/bp_be_dcache_decode_queue.sv
// Registered D$ packet decoder with an els_p-deep FIFO between the MMU/TLB
// issue logic and the dcache TL stage. L1-resident AMOs can be split into a
// load micro-op followed by a store micro-op.

package bp_be_dcache_decode_queue_pkg;

  localparam int dword_width_gp       = 64;
  localparam int page_offset_width_gp = 12;
  localparam int reg_addr_width_gp    = 5;

  typedef enum logic [1:0] {
    e_none = 2'd0,
    e_l1   = 2'd1,
    e_l2   = 2'd2
  } bp_amo_support_e;

  typedef enum logic [5:0] {
    e_dcache_op_lb       = 6'd0,
    e_dcache_op_lh       = 6'd1,
    e_dcache_op_lw       = 6'd2,
    e_dcache_op_ld       = 6'd3,
    e_dcache_op_lbu      = 6'd4,
    e_dcache_op_lhu      = 6'd5,
    e_dcache_op_lwu      = 6'd6,
    e_dcache_op_sb       = 6'd7,
    e_dcache_op_sh       = 6'd8,
    e_dcache_op_sw       = 6'd9,
    e_dcache_op_sd       = 6'd10,
    e_dcache_op_lrw      = 6'd11,
    e_dcache_op_scw      = 6'd12,
    e_dcache_op_lrd      = 6'd13,
    e_dcache_op_scd      = 6'd14,
    e_dcache_op_amoswapw = 6'd15,
    e_dcache_op_amoaddw  = 6'd16,
    e_dcache_op_amoxorw  = 6'd17,
    e_dcache_op_amoandw  = 6'd18,
    e_dcache_op_amoorw   = 6'd19,
    e_dcache_op_amominw  = 6'd20,
    e_dcache_op_amomaxw  = 6'd21,
    e_dcache_op_amominuw = 6'd22,
    e_dcache_op_amomaxuw = 6'd23,
    e_dcache_op_amoswapd = 6'd24,
    e_dcache_op_amoaddd  = 6'd25,
    e_dcache_op_amoxord  = 6'd26,
    e_dcache_op_amoandd  = 6'd27,
    e_dcache_op_amoord   = 6'd28,
    e_dcache_op_amomind  = 6'd29,
    e_dcache_op_amomaxd  = 6'd30,
    e_dcache_op_amominud = 6'd31,
    e_dcache_op_amomaxud = 6'd32,
    e_dcache_op_fencei   = 6'd33
  } bp_be_dcache_fu_op_e;

  typedef struct packed {
    logic [reg_addr_width_gp-1:0]    rd_addr;
    bp_be_dcache_fu_op_e             opcode;
    logic [page_offset_width_gp-1:0] page_offset;
    logic [dword_width_gp-1:0]       data;
  } bp_be_dcache_pkt_s;

  typedef struct packed {
    logic load_op;
    logic store_op;
    logic signed_op;
    logic byte_op;
    logic half_op;
    logic word_op;
    logic double_op;
    logic lr_op;
    logic sc_op;
    logic amoswap_op;
    logic amoadd_op;
    logic amoxor_op;
    logic amoand_op;
    logic amoor_op;
    logic amomin_op;
    logic amomax_op;
    logic amominu_op;
    logic amomaxu_op;
    logic fencei_op;
    logic no_return;
    logic l2_op;
  } bp_be_dcache_pipeline_s;

  localparam int dcache_pkt_width_lp             = $bits(bp_be_dcache_pkt_s);
  localparam int dcache_pipeline_struct_width_lp = $bits(bp_be_dcache_pipeline_s);

endpackage

module bp_be_dcache_decode_queue
  import bp_be_dcache_decode_queue_pkg::*;
  #(parameter int              els_p                  = 4
   ,parameter int              amo_split_p            = 1
   ,parameter bp_amo_support_e lr_sc_p                = e_l1
   ,parameter bp_amo_support_e amo_swap_p             = e_l1
   ,parameter bp_amo_support_e amo_fetch_logic_p      = e_l2
   ,parameter bp_amo_support_e amo_fetch_arithmetic_p = e_l1
   )
  (input  logic                                       clk_i
  ,input  logic                                       reset_i
  ,input  logic                                       poison_i
  ,input  logic                                       v_i
  ,input  logic [dcache_pkt_width_lp-1:0]             pkt_i
  ,output logic                                       ready_o
  ,output logic                                       v_o
  ,output logic [dcache_pipeline_struct_width_lp-1:0] decoded_o
  ,output logic [dcache_pkt_width_lp-1:0]             pkt_o
  ,input  logic                                       yumi_i
  );

  localparam int ptr_width_lp = $clog2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);

  typedef logic [ptr_width_lp-1:0] ptr_t;
  typedef logic [cnt_width_lp-1:0] cnt_t;

  typedef struct packed {
    bp_be_dcache_pipeline_s decoded;
    bp_be_dcache_pkt_s      pkt;
  } entry_s;

  typedef enum logic {e_pass, e_split} state_e;

  // Standard D$ decode; l2_op comes from the config field of the opcode class
  function automatic bp_be_dcache_pipeline_s decode_pkt(input bp_be_dcache_pkt_s pkt);
    bp_be_dcache_pipeline_s d;
    bp_be_dcache_fu_op_e    op;
    logic is_load, is_store, is_lr, is_sc, is_amo, is_fencei, is_unsigned;
    logic is_amo_logic, is_amo_arith;
    op          = pkt.opcode;
    is_load     = op inside {e_dcache_op_lb, e_dcache_op_lh, e_dcache_op_lw, e_dcache_op_ld,
                             e_dcache_op_lbu, e_dcache_op_lhu, e_dcache_op_lwu};
    is_store    = op inside {e_dcache_op_sb, e_dcache_op_sh, e_dcache_op_sw, e_dcache_op_sd};
    is_lr       = op inside {e_dcache_op_lrw, e_dcache_op_lrd};
    is_sc       = op inside {e_dcache_op_scw, e_dcache_op_scd};
    is_amo      = op inside {[e_dcache_op_amoswapw:e_dcache_op_amomaxud]};
    is_fencei   = (op == e_dcache_op_fencei);
    is_unsigned = op inside {e_dcache_op_lbu, e_dcache_op_lhu, e_dcache_op_lwu};

    d            = '0;
    d.load_op    = is_load | is_lr | is_amo;
    d.store_op   = is_store | is_sc | is_amo;
    d.signed_op  = (is_load & ~is_unsigned) | is_store | is_lr | is_sc | is_amo | is_fencei;
    d.byte_op    = op inside {e_dcache_op_lb, e_dcache_op_lbu, e_dcache_op_sb};
    d.half_op    = op inside {e_dcache_op_lh, e_dcache_op_lhu, e_dcache_op_sh};
    d.word_op    = op inside {e_dcache_op_lw, e_dcache_op_lwu, e_dcache_op_sw, e_dcache_op_lrw,
                              e_dcache_op_scw, [e_dcache_op_amoswapw:e_dcache_op_amomaxuw]};
    d.double_op  = op inside {e_dcache_op_ld, e_dcache_op_sd, e_dcache_op_lrd, e_dcache_op_scd,
                              [e_dcache_op_amoswapd:e_dcache_op_amomaxud]};
    d.lr_op      = is_lr;
    d.sc_op      = is_sc;
    d.amoswap_op = op inside {e_dcache_op_amoswapw, e_dcache_op_amoswapd};
    d.amoadd_op  = op inside {e_dcache_op_amoaddw, e_dcache_op_amoaddd};
    d.amoxor_op  = op inside {e_dcache_op_amoxorw, e_dcache_op_amoxord};
    d.amoand_op  = op inside {e_dcache_op_amoandw, e_dcache_op_amoandd};
    d.amoor_op   = op inside {e_dcache_op_amoorw, e_dcache_op_amoord};
    d.amomin_op  = op inside {e_dcache_op_amominw, e_dcache_op_amomind};
    d.amomax_op  = op inside {e_dcache_op_amomaxw, e_dcache_op_amomaxd};
    d.amominu_op = op inside {e_dcache_op_amominuw, e_dcache_op_amominud};
    d.amomaxu_op = op inside {e_dcache_op_amomaxuw, e_dcache_op_amomaxud};
    d.fencei_op  = is_fencei;
    d.no_return  = is_store | is_fencei;

    is_amo_logic = d.amoxor_op | d.amoand_op | d.amoor_op;
    is_amo_arith = d.amoadd_op | d.amomin_op | d.amomax_op | d.amominu_op | d.amomaxu_op;
    d.l2_op      = ((is_lr | is_sc) & (lr_sc_p == e_l2))
                 | (d.amoswap_op    & (amo_swap_p == e_l2))
                 | (is_amo_logic    & (amo_fetch_logic_p == e_l2))
                 | (is_amo_arith    & (amo_fetch_arithmetic_p == e_l2));
    return d;
  endfunction

  entry_s            mem_r [els_p];
  ptr_t              wptr_r, rptr_r;
  cnt_t              count_r;
  state_e            state_r;
  bp_be_dcache_pkt_s split_pkt_r;

  bp_be_dcache_pkt_s      pkt_li;
  bp_be_dcache_pipeline_s in_decoded, split_a, split_b;
  entry_s                 wr_entry, head_entry;
  logic                   full, empty, in_is_amo, split_start;
  logic                   enq_pass, enq_split, enq, deq;

  assign pkt_li     = pkt_i;
  assign full       = (count_r == cnt_t'(els_p));
  assign empty      = (count_r == '0);
  assign ready_o    = ~full & (state_r == e_pass) & ~reset_i;
  assign head_entry = mem_r[rptr_r];
  assign v_o        = ~empty;
  assign decoded_o  = head_entry.decoded;
  assign pkt_o      = head_entry.pkt;

  // Decode the incoming packet, build both split halves and pick what gets written
  always_comb begin
    in_decoded         = decode_pkt(pkt_li);
    in_is_amo          = in_decoded.amoswap_op | in_decoded.amoadd_op | in_decoded.amoxor_op
                       | in_decoded.amoand_op | in_decoded.amoor_op | in_decoded.amomin_op
                       | in_decoded.amomax_op | in_decoded.amominu_op | in_decoded.amomaxu_op;
    split_start        = (amo_split_p != 0) & in_is_amo & ~in_decoded.l2_op;

    split_a            = in_decoded;
    split_a.store_op   = 1'b0;
    split_a.load_op    = 1'b1;
    split_a.signed_op  = 1'b1;
    split_a.amoswap_op = 1'b0;
    split_a.amoadd_op  = 1'b0;
    split_a.amoxor_op  = 1'b0;
    split_a.amoand_op  = 1'b0;
    split_a.amoor_op   = 1'b0;
    split_a.amomin_op  = 1'b0;
    split_a.amomax_op  = 1'b0;
    split_a.amominu_op = 1'b0;
    split_a.amomaxu_op = 1'b0;

    split_b            = decode_pkt(split_pkt_r);
    split_b.load_op    = 1'b0;

    enq_pass  = v_i & ready_o;
    enq_split = (state_r == e_split) & ~full;
    enq       = (enq_pass | enq_split) & ~poison_i;
    deq       = yumi_i & v_o & ~poison_i;

    wr_entry = '0;
    if (state_r == e_split) begin
      wr_entry.decoded = split_b;
      wr_entry.pkt     = split_pkt_r;
    end else if (split_start) begin
      wr_entry.decoded = split_a;
      wr_entry.pkt     = pkt_li;
    end else begin
      wr_entry.decoded = in_decoded;
      wr_entry.pkt     = pkt_li;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_r[wptr_r] <= wr_entry;
    end
  end

  // Remember the AMO being split so its store half can be issued next
  always_ff @(posedge clk_i) begin
    if (enq_pass & split_start & (state_r == e_pass)) begin
      split_pkt_r <= pkt_li;
    end
  end

  // Pointers, occupancy and split FSM; poison behaves like a reset
  always_ff @(posedge clk_i) begin
    if (reset_i | poison_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      state_r <= e_pass;
    end else begin
      if (enq) begin
        wptr_r <= wptr_r + ptr_t'(1);
      end
      if (deq) begin
        rptr_r <= rptr_r + ptr_t'(1);
      end
      if (enq & ~deq) begin
        count_r <= count_r + cnt_t'(1);
      end else if (~enq & deq) begin
        count_r <= count_r - cnt_t'(1);
      end
      case (state_r)
        e_pass:  if (enq_pass & split_start) state_r <= e_split;
        e_split: if (~full) state_r <= e_pass;
        default: state_r <= e_pass;
      endcase
    end
  end

  // Consuming an empty queue is a protocol error by the TL stage
  assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));

endmodule

// File: tb/tb_bp_be_dcache_decode_queue.sv
// Self-checking bench for bp_be_dcache_decode_queue: a scoreboard of expected
// {decoded, pkt} entries is filled when packets are driven and drained as the
// head is consumed. A second instance covers the L2-resident AMO configuration.

module tb_bp_be_dcache_decode_queue;
  import bp_be_dcache_decode_queue_pkg::*;

  localparam bp_amo_support_e tb_lr_sc     = e_l1;
  localparam bp_amo_support_e tb_swap      = e_l1;
  localparam bp_amo_support_e tb_logic     = e_l2;
  localparam bp_amo_support_e tb_arith     = e_l1;
  localparam bp_amo_support_e tb_arith_alt = e_l2;

  typedef struct {
    bp_be_dcache_pipeline_s dec;
    bp_be_dcache_pkt_s      pkt;
  } sb_entry_t;

  logic clk = 1'b0;
  logic reset, poison;
  logic v_i, yumi, ready, v_o;
  bp_be_dcache_pkt_s      pkt_i, pkt_o;
  bp_be_dcache_pipeline_s dec_o;
  logic v2_i, yumi2, ready2, v2_o;
  bp_be_dcache_pkt_s      pkt2_i, pkt2_o;
  bp_be_dcache_pipeline_s dec2_o;

  int total = 0;
  int bad   = 0;
  sb_entry_t sb[$];

  bp_be_dcache_decode_queue #(
    .els_p(4), .amo_split_p(1), .lr_sc_p(tb_lr_sc), .amo_swap_p(tb_swap),
    .amo_fetch_logic_p(tb_logic), .amo_fetch_arithmetic_p(tb_arith)
  ) dut (
    .clk_i(clk), .reset_i(reset), .poison_i(poison), .v_i(v_i), .pkt_i(pkt_i),
    .ready_o(ready), .v_o(v_o), .decoded_o(dec_o), .pkt_o(pkt_o), .yumi_i(yumi)
  );

  bp_be_dcache_decode_queue #(
    .els_p(4), .amo_split_p(1), .lr_sc_p(tb_lr_sc), .amo_swap_p(tb_swap),
    .amo_fetch_logic_p(tb_logic), .amo_fetch_arithmetic_p(tb_arith_alt)
  ) dut_l2 (
    .clk_i(clk), .reset_i(reset), .poison_i(poison), .v_i(v2_i), .pkt_i(pkt2_i),
    .ready_o(ready2), .v_o(v2_o), .decoded_o(dec2_o), .pkt_o(pkt2_o), .yumi_i(yumi2)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bp_be_dcache_pkt_s mk(input bp_be_dcache_fu_op_e op, input int n);
    bp_be_dcache_pkt_s p;
    p.rd_addr     = 5'(n);
    p.opcode      = op;
    p.page_offset = 12'(n * 8);
    p.data        = {$urandom, $urandom};
    return p;
  endfunction

  // Reference decode written as an opcode table
  function automatic bp_be_dcache_pipeline_s model_decode(input bp_be_dcache_pkt_s p,
                                                          input bp_amo_support_e arith);
    bp_be_dcache_pipeline_s d;
    int code, base, k;
    d    = '0;
    code = int'(p.opcode);
    base = int'(e_dcache_op_amoswapw);
    case (p.opcode)
      e_dcache_op_lb:  begin d.load_op = 1; d.signed_op = 1; d.byte_op = 1; end
      e_dcache_op_lh:  begin d.load_op = 1; d.signed_op = 1; d.half_op = 1; end
      e_dcache_op_lw:  begin d.load_op = 1; d.signed_op = 1; d.word_op = 1; end
      e_dcache_op_ld:  begin d.load_op = 1; d.signed_op = 1; d.double_op = 1; end
      e_dcache_op_lbu: begin d.load_op = 1; d.byte_op = 1; end
      e_dcache_op_lhu: begin d.load_op = 1; d.half_op = 1; end
      e_dcache_op_lwu: begin d.load_op = 1; d.word_op = 1; end
      e_dcache_op_sb:  begin d.store_op = 1; d.signed_op = 1; d.byte_op = 1; d.no_return = 1; end
      e_dcache_op_sh:  begin d.store_op = 1; d.signed_op = 1; d.half_op = 1; d.no_return = 1; end
      e_dcache_op_sw:  begin d.store_op = 1; d.signed_op = 1; d.word_op = 1; d.no_return = 1; end
      e_dcache_op_sd:  begin d.store_op = 1; d.signed_op = 1; d.double_op = 1; d.no_return = 1; end
      e_dcache_op_lrw: begin d.load_op = 1; d.signed_op = 1; d.word_op = 1; d.lr_op = 1; d.l2_op = (tb_lr_sc == e_l2); end
      e_dcache_op_scw: begin d.store_op = 1; d.signed_op = 1; d.word_op = 1; d.sc_op = 1; d.l2_op = (tb_lr_sc == e_l2); end
      e_dcache_op_lrd: begin d.load_op = 1; d.signed_op = 1; d.double_op = 1; d.lr_op = 1; d.l2_op = (tb_lr_sc == e_l2); end
      e_dcache_op_scd: begin d.store_op = 1; d.signed_op = 1; d.double_op = 1; d.sc_op = 1; d.l2_op = (tb_lr_sc == e_l2); end
      e_dcache_op_fencei: begin d.signed_op = 1; d.fencei_op = 1; d.no_return = 1; end
      default: begin
        if (code >= base && code < base + 18) begin
          k = (code - base) % 9;
          d.load_op = 1; d.store_op = 1; d.signed_op = 1;
          if (code - base >= 9) d.double_op = 1; else d.word_op = 1;
          case (k)
            0: begin d.amoswap_op = 1; d.l2_op = (tb_swap == e_l2);  end
            1: begin d.amoadd_op  = 1; d.l2_op = (arith == e_l2);    end
            2: begin d.amoxor_op  = 1; d.l2_op = (tb_logic == e_l2); end
            3: begin d.amoand_op  = 1; d.l2_op = (tb_logic == e_l2); end
            4: begin d.amoor_op   = 1; d.l2_op = (tb_logic == e_l2); end
            5: begin d.amomin_op  = 1; d.l2_op = (arith == e_l2);    end
            6: begin d.amomax_op  = 1; d.l2_op = (arith == e_l2);    end
            7: begin d.amominu_op = 1; d.l2_op = (arith == e_l2);    end
            default: begin d.amomaxu_op = 1; d.l2_op = (arith == e_l2); end
          endcase
        end
      end
    endcase
    return d;
  endfunction

  // Queue the entries the main instance should produce for an accepted packet
  task automatic push_expected(input bp_be_dcache_pkt_s p);
    sb_entry_t e;
    bp_be_dcache_pipeline_s d;
    int code;
    d    = model_decode(p, tb_arith);
    code = int'(p.opcode);
    e.pkt = p;
    if (code >= int'(e_dcache_op_amoswapw) && code <= int'(e_dcache_op_amomaxud) && !d.l2_op) begin
      e.dec = '0;
      e.dec.load_op   = 1;
      e.dec.signed_op = 1;
      e.dec.word_op   = d.word_op;
      e.dec.double_op = d.double_op;
      sb.push_back(e);
      e.dec = d;
      e.dec.load_op = 0;
      sb.push_back(e);
    end else begin
      e.dec = d;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1; poison = 0; v_i = 0; yumi = 0; v2_i = 0; yumi2 = 0;
    pkt_i = '0; pkt2_i = '0;
    tick(); tick();
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
    total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_v: got %b want 0", v_o); end
    total++; if (ready2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready2: got %b want 0", ready2); end
    reset = 0;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_ready: got %b want 1", ready); end
    total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_v: got %b want 0", v_o); end
    total++; if (v2_o !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_v2: got %b want 0", v2_o); end
  endtask

  task automatic test_stream();
    bp_be_dcache_pkt_s pkts[5];
    sb_entry_t e;
    int sent;
    pkts[0] = mk(e_dcache_op_lw, 1);
    pkts[1] = mk(e_dcache_op_ld, 2);
    pkts[2] = mk(e_dcache_op_lbu, 3);
    pkts[3] = mk(e_dcache_op_sd, 4);
    pkts[4] = mk(bp_be_dcache_fu_op_e'(6'd50), 5);
    sent = 0;
    tick();
    for (int cyc = 0; cyc < 8; cyc++) begin
      yumi = 0;
      total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL stream_ready c%0d: got %b want 1", cyc, ready); end
      total++; if (v_o !== (sb.size() != 0)) begin bad++; $display("[TB] FAIL stream_v c%0d: got %b want %b", cyc, v_o, sb.size() != 0); end
      if (cyc == 1) begin
        total++; if ({dec_o.word_op, dec_o.signed_op} !== 2'b11) begin bad++; $display("[TB] FAIL stream_lw_flags: got %b want 11", {dec_o.word_op, dec_o.signed_op}); end
      end
      if (cyc == 3) begin
        total++; if ({dec_o.byte_op, dec_o.signed_op} !== 2'b10) begin bad++; $display("[TB] FAIL stream_lbu_flags: got %b want 10", {dec_o.byte_op, dec_o.signed_op}); end
      end
      if (v_o && sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (dec_o !== e.dec || pkt_o !== e.pkt) begin
          bad++; $display("[TB] FAIL stream_head c%0d: got dec=%h pkt=%h want dec=%h pkt=%h", cyc, dec_o, pkt_o, e.dec, e.pkt);
        end
        yumi = 1;
      end
      if (sent < 5) begin
        v_i = 1; pkt_i = pkts[sent]; push_expected(pkts[sent]); sent++;
      end else begin
        v_i = 0;
      end
      tick();
    end
    yumi = 0; v_i = 0;
    total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL stream_end_v: got %b want 0", v_o); end
  endtask

  task automatic test_fill();
    sb_entry_t e;
    bp_be_dcache_pkt_s p;
    for (int i = 0; i < 4; i++) begin
      p = mk(e_dcache_op_lw, 8 + i);
      v_i = 1; pkt_i = p;
      total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL fill_ready%0d: got %b want 1", i, ready); end
      push_expected(p);
      tick();
    end
    v_i = 0;
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_full_ready: got %b want 0", ready); end
    e = sb.pop_front();
    total++; if (dec_o !== e.dec || pkt_o !== e.pkt) begin bad++; $display("[TB] FAIL fill_head0: got pkt=%h want pkt=%h", pkt_o, e.pkt); end
    yumi = 1;
    tick();
    yumi = 0;
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL fill_ready_after_yumi: got %b want 1", ready); end
    p = mk(e_dcache_op_ld, 20);
    v_i = 1; pkt_i = p; push_expected(p);
    tick();
    v_i = 0;
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_refull_ready: got %b want 0", ready); end
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      yumi = 0;
      if (v_o) begin
        e = sb.pop_front();
        total++; if (dec_o !== e.dec || pkt_o !== e.pkt) begin bad++; $display("[TB] FAIL fill_drain c%0d: got dec=%h pkt=%h want dec=%h pkt=%h", c, dec_o, pkt_o, e.dec, e.pkt); end
        yumi = 1;
      end
      tick();
    end
    yumi = 0;
    total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL fill_drain_left: got %0d want 0", sb.size()); end
    total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL fill_empty_v: got %b want 0", v_o); end
  endtask

  task automatic test_split();
    sb_entry_t e;
    bp_be_dcache_pkt_s p;
    bp_be_dcache_pipeline_s want;
    p = mk(e_dcache_op_amoaddw, 12);
    v_i = 1; pkt_i = p;
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL split_ready_in: got %b want 1", ready); end
    push_expected(p);
    tick();
    v_i = 0;
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL split_ready_low: got %b want 0", ready); end
    total++; if (v_o !== 1'b1) begin bad++; $display("[TB] FAIL split_a_v: got %b want 1", v_o); end
    e = sb.pop_front();
    total++; if (dec_o !== e.dec || pkt_o !== e.pkt) begin bad++; $display("[TB] FAIL split_a: got dec=%h want dec=%h", dec_o, e.dec); end
    total++; if ({dec_o.load_op, dec_o.store_op, dec_o.amoadd_op, dec_o.word_op} !== 4'b1001) begin bad++; $display("[TB] FAIL split_a_flags: got %b want 1001", {dec_o.load_op, dec_o.store_op, dec_o.amoadd_op, dec_o.word_op}); end
    yumi = 1;
    tick();
    yumi = 0;
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL split_ready_back: got %b want 1", ready); end
    total++; if (v_o !== 1'b1) begin bad++; $display("[TB] FAIL split_b_v: got %b want 1", v_o); end
    e = sb.pop_front();
    total++; if (dec_o !== e.dec || pkt_o !== e.pkt) begin bad++; $display("[TB] FAIL split_b: got dec=%h want dec=%h", dec_o, e.dec); end
    total++; if ({dec_o.store_op, dec_o.load_op, dec_o.amoadd_op} !== 3'b101) begin bad++; $display("[TB] FAIL split_b_flags: got %b want 101", {dec_o.store_op, dec_o.load_op, dec_o.amoadd_op}); end
    yumi = 1;
    tick();
    yumi = 0;
    total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL split_done_v: got %b want 0", v_o); end

    p = mk(e_dcache_op_amoaddw, 13);
    want = model_decode(p, tb_arith_alt);
    v2_i = 1; pkt2_i = p;
    tick();
    v2_i = 0;
    total++; if (ready2 !== 1'b1) begin bad++; $display("[TB] FAIL l2_ready: got %b want 1", ready2); end
    total++; if (v2_o !== 1'b1) begin bad++; $display("[TB] FAIL l2_v: got %b want 1", v2_o); end
    total++; if (dec2_o !== want || pkt2_o !== p) begin bad++; $display("[TB] FAIL l2_entry: got dec=%h want dec=%h", dec2_o, want); end
    total++; if (dec2_o.l2_op !== 1'b1) begin bad++; $display("[TB] FAIL l2_op: got %b want 1", dec2_o.l2_op); end
    yumi2 = 1;
    tick();
    yumi2 = 0;
    total++; if (v2_o !== 1'b0) begin bad++; $display("[TB] FAIL l2_single_entry: got %b want 0", v2_o); end
  endtask

  task automatic test_split_stall();
    sb_entry_t e;
    bp_be_dcache_pkt_s p, first;
    for (int i = 0; i < 3; i++) begin
      p = mk(e_dcache_op_lw, 16 + i);
      if (i == 0) first = p;
      v_i = 1; pkt_i = p; push_expected(p);
      tick();
    end
    p = mk(e_dcache_op_amoswapd, 24);
    v_i = 1; pkt_i = p;
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_ready_in: got %b want 1", ready); end
    push_expected(p);
    tick();
    v_i = 0;
    for (int c = 0; c < 2; c++) begin
      total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready c%0d: got %b want 0", c, ready); end
      total++; if (pkt_o !== first) begin bad++; $display("[TB] FAIL stall_head c%0d: got %h want %h", c, pkt_o, first); end
      tick();
    end
    e = sb.pop_front();
    total++; if (dec_o !== e.dec || pkt_o !== e.pkt) begin bad++; $display("[TB] FAIL stall_pop: got pkt=%h want pkt=%h", pkt_o, e.pkt); end
    yumi = 1;
    tick();
    yumi = 0;
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_b_cycle_ready: got %b want 0", ready); end
    tick();
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_full_ready: got %b want 0", ready); end
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      yumi = 0;
      if (v_o) begin
        e = sb.pop_front();
        total++; if (dec_o !== e.dec || pkt_o !== e.pkt) begin bad++; $display("[TB] FAIL stall_drain c%0d: got dec=%h pkt=%h want dec=%h pkt=%h", c, dec_o, pkt_o, e.dec, e.pkt); end
        yumi = 1;
      end
      tick();
    end
    yumi = 0;
    total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL stall_drain_left: got %0d want 0", sb.size()); end
    total++; if ({v_o, ready} !== 2'b01) begin bad++; $display("[TB] FAIL stall_end: got v/ready=%b want 01", {v_o, ready}); end
  endtask

  task automatic test_poison();
    sb_entry_t e;
    bp_be_dcache_pkt_s p;
    for (int i = 0; i < 3; i++) begin
      p = mk(e_dcache_op_lw, 4 + i);
      v_i = 1; pkt_i = p;
      tick();
    end
    v_i = 1; pkt_i = mk(e_dcache_op_lw, 30); poison = 1; yumi = 1;
    tick();
    v_i = 0; poison = 0; yumi = 0;
    sb.delete();
    total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL poison_v: got %b want 0", v_o); end
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL poison_ready: got %b want 1", ready); end
    p = mk(e_dcache_op_lh, 31);
    v_i = 1; pkt_i = p; push_expected(p);
    tick();
    v_i = 0;
    e = sb.pop_front();
    total++; if (dec_o !== e.dec || pkt_o !== e.pkt) begin bad++; $display("[TB] FAIL poison_next_head: got pkt=%h want pkt=%h", pkt_o, e.pkt); end
    yumi = 1;
    tick();
    yumi = 0;
    total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL poison_lost_pkt: got %b want 0", v_o); end

    v_i = 1; pkt_i = mk(e_dcache_op_amoaddw, 2);
    tick();
    v_i = 0; poison = 1;
    tick();
    poison = 0;
    total++; if ({v_o, ready} !== 2'b01) begin bad++; $display("[TB] FAIL poison_split: got v/ready=%b want 01", {v_o, ready}); end
    tick();
    total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL poison_split_no_b: got %b want 0", v_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      v_i = 1; pkt_i = mk(e_dcache_op_ld, 10 + i);
      tick();
    end
    v_i = 0;
    total++; if (v_o !== 1'b1) begin bad++; $display("[TB] FAIL mid_queued_v: got %b want 1", v_o); end
    reset = 1;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_ready: got %b want 0", ready); end
    tick();
    total++; if ({v_o, ready} !== 2'b00) begin bad++; $display("[TB] FAIL mid_reset_state: got v/ready=%b want 00", {v_o, ready}); end
    reset = 0;
    #1;
    total++; if ({v_o, ready} !== 2'b01) begin bad++; $display("[TB] FAIL mid_after_reset: got v/ready=%b want 01", {v_o, ready}); end
    sb.delete();
  endtask

  initial begin
    $display("[TB] starting bp_be_dcache_decode_queue bench");
    test_reset();
    test_stream();
    test_fill();
    test_split();
    test_split_stall();
    test_poison();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
